// File: rtl/pwm_sample_sched.sv
// Audio sample-rate scheduler with a two-source round-robin arbiter.
// Each rate tick pulls one signed 8-bit sample and presents it, with a strobe, to the PWM stage.
module pwm_sample_sched #(
  parameter int DIV_W         = 12,
  parameter bit UNDERRUN_HOLD = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] rate_div,
  input  logic             s0_valid,
  input  logic [7:0]       s0_sample,
  output logic             s0_ready,
  input  logic             s1_valid,
  input  logic [7:0]       s1_sample,
  output logic             s1_ready,
  output logic [7:0]       sample_out,
  output logic             sample_stb,
  output logic             grant_id,
  output logic [7:0]       underrun_cnt
);

  typedef enum logic [1:0] {IDLE, COUNT, FETCH, LOAD} state_t;

  state_t           state;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] period;
  logic [DIV_W-1:0] div_eff;
  logic [1:0]       rdy_q;
  logic             last_grant;
  logic             fetch_gnt;
  logic             tick;
  logic             pick;
  logic             xfer;
  logic [7:0]       fetch_data;

  assign div_eff = (rate_div == '0) ? DIV_W'(1) : rate_div;

  // The counter never stops while running, so a tick can land in the LOAD cycle
  // when the period is 2; FETCH always sees cnt==0 and can never tick.
  assign tick = ((state == COUNT) || (state == LOAD)) && (cnt == period);

  always_comb begin
    pick = s1_valid;
    if (s0_valid && s1_valid) pick = ~last_grant;
  end

  // Gating with enable makes a disable during FETCH abandon the transfer at once.
  assign s0_ready   = rdy_q[0] & enable;
  assign s1_ready   = rdy_q[1] & enable;
  assign xfer       = fetch_gnt ? (s1_valid & s1_ready) : (s0_valid & s0_ready);
  assign fetch_data = fetch_gnt ? s1_sample : s0_sample;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      rdy_q        <= '0;
      last_grant   <= 1'b1;
      fetch_gnt    <= 1'b0;
      sample_out   <= '0;
      sample_stb   <= 1'b0;
      grant_id     <= 1'b0;
      underrun_cnt <= '0;
    end else if (!enable) begin
      state      <= IDLE;
      cnt        <= '0;
      rdy_q      <= '0;
      sample_out <= '0;
      sample_stb <= 1'b0;
    end else begin
      sample_stb <= 1'b0;
      case (state)
        IDLE: begin
          state  <= COUNT;
          cnt    <= '0;
          period <= div_eff;
        end
        FETCH: begin
          state      <= LOAD;
          cnt        <= cnt + 1'b1;
          rdy_q      <= '0;
          sample_stb <= 1'b1;
          if (xfer) begin
            sample_out <= fetch_data;
            grant_id   <= fetch_gnt;
          end else begin
            if (!UNDERRUN_HOLD) sample_out <= '0;
            if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
          end
        end
        default: begin
          if (tick) begin
            state  <= FETCH;
            cnt    <= '0;
            period <= div_eff;
            // With no source valid, no ready is raised and FETCH resolves as underrun.
            if (s0_valid || s1_valid) begin
              rdy_q      <= pick ? 2'b10 : 2'b01;
              fetch_gnt  <= pick;
              last_grant <= pick;
            end
          end else begin
            state <= COUNT;
            cnt   <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_sample_sched.sv
// Bench for pwm_sample_sched: hold and zero underrun variants side by side, an
// event-scheduled reference model, and directed scenarios with literal expectations.
module tb_pwm_sample_sched;
  localparam int DIV_W = 12;

  logic             clk = 1'b0;
  logic             rst_n, enable;
  logic [DIV_W-1:0] rate_div;
  logic             s0_valid, s1_valid;
  logic [7:0]       s0_sample, s1_sample;
  logic             h_s0r, h_s1r, h_stb, h_gid, z_s0r, z_s1r, z_stb, z_gid;
  logic [7:0]       h_out, h_uc, z_out, z_uc;

  int vectors = 0;
  int errors  = 0;
  int cycle   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  pwm_sample_sched #(.DIV_W(DIV_W), .UNDERRUN_HOLD(1'b1)) u_hold (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rate_div(rate_div),
    .s0_valid(s0_valid), .s0_sample(s0_sample), .s0_ready(h_s0r),
    .s1_valid(s1_valid), .s1_sample(s1_sample), .s1_ready(h_s1r),
    .sample_out(h_out), .sample_stb(h_stb), .grant_id(h_gid), .underrun_cnt(h_uc));

  pwm_sample_sched #(.DIV_W(DIV_W), .UNDERRUN_HOLD(1'b0)) u_zero (
    .clk(clk), .rst_n(rst_n), .enable(enable), .rate_div(rate_div),
    .s0_valid(s0_valid), .s0_sample(s0_sample), .s0_ready(z_s0r),
    .s1_valid(s1_valid), .s1_sample(s1_sample), .s1_ready(z_s1r),
    .sample_out(z_out), .sample_stb(z_stb), .grant_id(z_gid), .underrun_cnt(z_uc));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Sources: mode 0 idle, 1 always valid (sample += step per transfer), 2 one sample then idle.
  int         s_mode[2], s_gen[2], s_seen[2];
  logic [7:0] s_base[2], s_step[2];

  task automatic src(input int i, input int mode, input logic [7:0] base, input logic [7:0] step);
    s_mode[i] = mode; s_base[i] = base; s_step[i] = step; s_gen[i]++;
  endtask

  initial begin
    bit hs0, hs1;
    s0_valid = 0; s1_valid = 0; s0_sample = 0; s1_sample = 0;
    forever begin
      @(negedge clk);
      hs0 = s0_valid && h_s0r;
      hs1 = s1_valid && h_s1r;
      @(posedge clk); #1;
      if (s_gen[0] != s_seen[0]) begin
        s_seen[0] = s_gen[0]; s0_valid = (s_mode[0] != 0); s0_sample = s_base[0];
      end else if (hs0) begin
        if (s_mode[0] == 2) s0_valid = 1'b0; else s0_sample = s0_sample + s_step[0];
      end
      if (s_gen[1] != s_seen[1]) begin
        s_seen[1] = s_gen[1]; s1_valid = (s_mode[1] != 0); s1_sample = s_base[1];
      end else if (hs1) begin
        if (s_mode[1] == 2) s1_valid = 1'b0; else s1_sample = s1_sample + s_step[1];
      end
    end
  end

  // Reference model: absolute edge numbers of the next tick decision and the next load.
  int         m_e = 0, m_tick = 0, m_load = -1, m_uc = 0;
  bit         m_run = 0, m_fa = 0, m_fg = 0, m_fu = 0, m_last = 1, m_stb = 0, m_gid = 0;
  logic [7:0] m_oh = '0, m_oz = '0;

  function automatic int eff(input logic [DIV_W-1:0] r);
    return (r == '0) ? 1 : int'(r);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_run = 0; m_fa = 0; m_load = -1; m_last = 1; m_stb = 0; m_gid = 0;
      m_uc = 0; m_oh = '0; m_oz = '0;
    end else begin
      m_e++;
      m_stb = 0;
      if (!enable) begin
        m_run = 0; m_fa = 0; m_load = -1; m_oh = '0; m_oz = '0;
      end else if (!m_run) begin
        m_run  = 1;
        m_tick = m_e + eff(rate_div);
      end else begin
        if (m_e == m_load) begin
          m_fa = 0; m_stb = 1;
          if (!m_fu) begin
            m_oh  = m_fg ? s1_sample : s0_sample;
            m_oz  = m_oh;
            m_gid = m_fg;
          end else begin
            m_oz = '0;
            if (m_uc < 255) m_uc++;
          end
        end
        if (m_e == m_tick + 1) begin
          m_fu = !(s0_valid || s1_valid);
          if (s0_valid && s1_valid) m_fg = !m_last;
          else if (!m_fu)           m_fg = s1_valid;
          if (!m_fu) m_last = m_fg;
          m_fa   = !m_fu;
          m_load = m_e + 1;
          m_tick = m_e + eff(rate_div);
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    chk("s0_ready", {h_s0r, z_s0r}, {2{m_fa && !m_fg && enable}});
    chk("s1_ready", {h_s1r, z_s1r}, {2{m_fa && m_fg && enable}});
    chk("sample_out", {h_out, z_out}, {m_oh, m_oz});
    chk("stb_gid", {h_stb, z_stb, h_gid, z_gid}, {m_stb, m_stb, m_gid, m_gid});
    chk("underrun_cnt", {h_uc, z_uc}, {2{8'(m_uc)}});
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_rdy(input int bound, output int at, output int which);
    at = -1; which = -1;
    for (int i = 0; i < bound; i++) begin
      if (h_s0r || h_s1r) begin at = cycle; which = int'(h_s1r); return; end
      cyc(1);
    end
    vectors++; errors++;
    $display("FAIL ready_timeout: no ready within %0d cycles", bound);
  endtask

  task automatic wait_stb(input int bound, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      if (h_stb) begin at = cycle; return; end
      cyc(1);
    end
    vectors++; errors++;
    $display("FAIL stb_timeout: no strobe within %0d cycles", bound);
  endtask

  initial begin
    int t0, t1, w, ten;
    logic [7:0] v;
    int exp_g[3] = '{0, 1, 0};
    logic [7:0] exp_s[3] = '{8'd100, 8'hCE, 8'd100};

    rst_n = 1; enable = 0; rate_div = 9;
    #2 rst_n = 0;
    cyc(3);
    chk("reset_state", {h_s0r, h_s1r, h_out, h_stb, h_gid, h_uc, z_out, z_uc}, '0);

    // Tie-break alternation from reset: 100, -50, 100 with a 5-cycle period
    src(0, 1, 8'd100, 8'd0); src(1, 1, 8'hCE, 8'd0);
    rate_div = 4; rst_n = 1; enable = 1;
    t0 = 0;
    for (int k = 0; k < 3; k++) begin
      wait_rdy(20, t1, w);
      chk("B_grant", w, exp_g[k]);
      if (k > 0) chk("B_period", t1 - t0, 5);
      t0 = t1;
      cyc(1);
      chk("B_load", {h_stb, h_out, h_gid, z_out}, {1'b1, exp_s[k], 1'(exp_g[k]), exp_s[k]});
    end

    // Single source, rate_div=9: one transfer every 10 cycles
    enable = 0; cyc(2);
    src(1, 0, 8'd0, 8'd0); src(0, 1, 8'd10, 8'd3); rate_div = 9; enable = 1; ten = cycle;
    wait_rdy(40, t0, w);
    chk("A_first_tick", t0 - ten, 11);
    v = s0_sample; cyc(1);
    chk("A_load", {h_stb, h_out}, {1'b1, v});
    for (int k = 0; k < 2; k++) begin
      wait_rdy(20, t1, w);
      chk("A_period", t1 - t0, 10);
      chk("A_src", w, 0);
      t0 = t1; v = s0_sample; cyc(1);
      chk("A_load", {h_stb, h_out}, {1'b1, v});
    end

    // Underrun after a -7 sample: hold keeps -7, zero variant outputs 0
    enable = 0; cyc(2);
    src(0, 2, 8'hF9, 8'd0); rate_div = 3; enable = 1;
    wait_rdy(20, t0, w); cyc(1);
    chk("C_grant", {h_out, z_out, h_stb}, {8'hF9, 8'hF9, 1'b1});
    cyc(1); wait_stb(20, t0);
    chk("C_under1", {h_out, z_out, h_gid, h_uc, z_uc}, {8'hF9, 8'h00, 1'b0, 8'd1, 8'd1});
    cyc(1); wait_stb(20, t0);
    chk("C_under2", {h_out, z_out, h_uc, z_uc}, {8'hF9, 8'h00, 8'd2, 8'd2});

    // rate_div=0 behaves as 1: two-cycle period, then counter saturation
    rate_div = 0; cyc(10);
    wait_stb(10, t0); cyc(1); wait_stb(10, t1);
    chk("D_period2", t1 - t0, 2);
    cyc(620);
    chk("D_saturate", {h_uc, z_uc}, {8'd255, 8'd255});

    // Disable during FETCH abandons the transfer
    src(0, 1, 8'd55, 8'd0); rate_div = 5;
    wait_rdy(20, t0, w);
    enable = 0; #1;
    chk("E_ready_drop", {h_s0r, h_s1r, z_s0r, z_s1r}, '0);
    cyc(1);
    chk("E_disabled", {h_out, z_out, h_stb}, '0);
    cyc(2); enable = 1; ten = cycle;
    wait_rdy(20, t0, w);
    chk("E_reenable", t0 - ten, 7);
    cyc(1);
    chk("E_load", {h_stb, h_out}, {1'b1, 8'd55});

    // rate_div changes take effect only after the current wrap
    rate_div = 9;
    wait_rdy(20, t1, w);
    chk("F_old_period", t1 - t0, 6);
    t0 = t1; cyc(1);
    wait_rdy(20, t1, w);
    chk("F_period10", t1 - t0, 10);
    t0 = t1; cyc(3); rate_div = 3;
    wait_rdy(20, t1, w);
    chk("F_mid_change", t1 - t0, 10);
    t0 = t1; cyc(1);
    wait_rdy(20, t1, w);
    chk("F_period4", t1 - t0, 4);

    // Asynchronous reset mid-COUNT, then first tie goes to s0
    cyc(3);
    rst_n = 0; #1;
    chk("G_async_reset", {h_s0r, h_s1r, h_out, h_stb, h_gid, h_uc, z_out, z_uc}, '0);
    src(0, 1, 8'd11, 8'd0); src(1, 1, 8'd22, 8'd0);
    cyc(2); rst_n = 1;
    wait_rdy(20, t0, w);
    chk("G_first_tie", w, 0);
    cyc(1);
    chk("G_load", {h_out, h_gid, h_stb}, {8'd11, 1'b0, 1'b1});

    enable = 0; cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
